// File: rtl/rshift_pkg.sv
// Shared constants for the sequential right shifter: FSM encodings and
// shift-amount width derivation.
package rshift_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Width needed to hold a shift amount of 0..n-1 (never less than one bit).
   function automatic int sw_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rshift1.sv
// Single-position right shift with an explicit fill bit; also exposes the
// bit that falls off the bottom.
module rshift1 #(
   parameter int N = 8
) (
   input  logic [N-1:0] in,
   input  logic         fill,
   output logic [N-1:0] out,
   output logic         lsb_out
);

   assign out     = {fill, in[N-1:1]};
   assign lsb_out = in[0];

endmodule

// File: rtl/seq_rshift_unit.sv
// Multi-cycle right shifter (one bit per clock, logical or arithmetic) with a
// start/busy/done handshake. Optional RSHIFT_STICKY_EN adds the sticky output.
module seq_rshift_unit
   import rshift_pkg::*;
#(
   parameter int N  = 8,
   parameter int SW = sw_of(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [N-1:0]  A,
   input  logic [SW-1:0] shamt,
   input  logic          arith,
   output logic [N-1:0]  C,
   output logic          busy,
   output logic          done
`ifdef RSHIFT_STICKY_EN
   ,
   output logic          sticky
`endif
);

   logic [1:0]    state_reg;
   logic [N-1:0]  work_reg;
   logic [SW-1:0] cnt_reg;
   logic          fill_reg;
   logic [N-1:0]  c_reg;
   logic          busy_reg;
   logic          done_reg;
   logic [N-1:0]  shift_next;
   logic          accept;

   assign accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

`ifdef RSHIFT_STICKY_EN
   logic shift_lsb;
   logic sticky_acc_reg;
   logic sticky_reg;

   rshift1 #(.N(N)) u_rshift1 (
      .in      (work_reg),
      .fill    (fill_reg),
      .out     (shift_next),
      .lsb_out (shift_lsb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_acc_reg <= 1'b0;
         sticky_reg     <= 1'b0;
      end else if (state_reg == ST_SHIFT) begin
         sticky_acc_reg <= sticky_acc_reg | shift_lsb;
         if (cnt_reg == SW'(1))
            sticky_reg <= sticky_acc_reg | shift_lsb;
      end else if (accept) begin
         sticky_acc_reg <= 1'b0;
         if (shamt == '0)
            sticky_reg <= 1'b0;
      end
   end

   assign sticky = sticky_reg;
`else
   rshift1 #(.N(N)) u_rshift1 (
      .in      (work_reg),
      .fill    (fill_reg),
      .out     (shift_next),
      .lsb_out ()
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         work_reg  <= '0;
         cnt_reg   <= '0;
         fill_reg  <= 1'b0;
         c_reg     <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_SHIFT: begin
               work_reg <= shift_next;
               cnt_reg  <= cnt_reg - SW'(1);
               if (cnt_reg == SW'(1)) begin
                  state_reg <= ST_DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  c_reg     <= shift_next;
               end
            end
            // IDLE, DONE, and the unused encoding all fall back to accept-or-idle.
            default: begin
               if (accept) begin
                  work_reg <= A;
                  cnt_reg  <= shamt;
                  fill_reg <= arith & A[N-1];
                  if (shamt == '0) begin
                     state_reg <= ST_DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     c_reg     <= A;
                  end else begin
                     state_reg <= ST_SHIFT;
                     busy_reg  <= 1'b1;
                  end
               end else begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign C    = c_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_seq_rshift_unit.sv
// Directed bench for seq_rshift_unit (N=8) with hand-computed results;
// sticky checks are compiled in when RSHIFT_STICKY_EN is defined.
module tb_seq_rshift_unit;

   localparam int N  = 8;
   localparam int SW = 3;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [N-1:0]  A;
   logic [SW-1:0] shamt;
   logic          arith;
   logic [N-1:0]  C;
   logic          busy;
   logic          done;
`ifdef RSHIFT_STICKY_EN
   logic          sticky;
`endif

   int vec_cnt;
   int err_cnt;

   seq_rshift_unit #(.N(N), .SW(SW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .A      (A),
      .shamt  (shamt),
      .arith  (arith),
      .C      (C),
      .busy   (busy),
      .done   (done)
`ifdef RSHIFT_STICKY_EN
      ,
      .sticky (sticky)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Issue one op; latency counts rising edges from the accept edge (inclusive)
   // until done is seen, and busy_n counts sampled busy cycles in between.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [2:0] sh,
                         input logic ar, input logic [7:0] exp_c,
                         input int exp_lat, input int exp_busy, input logic exp_s);
      int n;
      int busy_n;
      @(negedge clk);
      start = 1'b1; A = a; shamt = sh; arith = ar;
      @(posedge clk); #1;
      start = 1'b0; A = 8'hxx;
      n = 1;
      busy_n = busy ? 1 : 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (busy) busy_n++;
      end
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_c"}, C, exp_c);
      chk({tag, "_busy_cycles"}, busy_n, exp_busy);
`ifdef RSHIFT_STICKY_EN
      chk({tag, "_sticky"}, sticky, exp_s);
`else
      if (exp_s === 1'bz) chk({tag, "_nosticky"}, 0, 1);
`endif
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_c_held"}, C, exp_c);
   endtask

   initial begin
      int n;
      int done_n;
      vec_cnt = 0;
      err_cnt = 0;
      rst_n = 1'b0; start = 1'b0; A = '0; shamt = '0; arith = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_c", C, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("t1_lsr3",    8'b1011_0010, 3'd3, 1'b0, 8'b0001_0110, 4, 3, 1'b1);
      run_op("t2_asr3",    8'b1011_0010, 3'd3, 1'b1, 8'b1111_0110, 4, 3, 1'b1);
      run_op("t3_sh0",     8'h5A,        3'd0, 1'b0, 8'h5A,        1, 0, 1'b0);
      run_op("asr1_neg",   8'h81,        3'd1, 1'b1, 8'hC0,        2, 1, 1'b1);
      run_op("asr7_pos",   8'h7F,        3'd7, 1'b1, 8'h00,        8, 7, 1'b1);
      run_op("lsr4",       8'h96,        3'd4, 1'b0, 8'h09,        5, 4, 1'b1);

      // Start during SHIFT must be ignored.
      @(negedge clk);
      start = 1'b1; A = 8'h80; shamt = 3'd7; arith = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      repeat (2) begin @(posedge clk); #1; n++; end
      start = 1'b1; A = 8'hFF; shamt = 3'd1; arith = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      chk("t4_ignore_lat", n, 8);
      chk("t4_ignore_c", C, 8'h01);

      // Reset in the middle of a shift: outputs clear at once, no done follows.
      @(negedge clk);
      start = 1'b1; A = 8'hF0; shamt = 3'd5; arith = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      chk("t4_rst_c", C, 0);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      done_n = 0;
      repeat (10) begin @(posedge clk); #1; if (done) done_n++; end
      chk("t4_rst_no_done", done_n, 0);
      chk("t4_rst_c_held", C, 0);

      // Back-to-back: start held high so the DONE cycle accepts the next op.
      @(negedge clk);
      start = 1'b1; A = 8'h3C; shamt = 3'd2; arith = 1'b0;
      @(posedge clk); #1;
      A = 8'h80; shamt = 3'd7; arith = 1'b1;
      n = 1;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      chk("t5_first_lat", n, 3);
      chk("t5_first_c", C, 8'h3C >> 2);
      @(posedge clk); #1;
      start = 1'b0;
      chk("t5_second_busy", busy, 1);
      chk("t5_second_done_low", done, 0);
      n = 1;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      chk("t5_second_lat", n, 8);
      chk("t5_second_c", C, 8'hFF);

`ifdef RSHIFT_STICKY_EN
      run_op("t6_sticky1", 8'h05, 3'd2, 1'b0, 8'h01, 3, 2, 1'b1);
      run_op("t6_sticky0", 8'h04, 3'd2, 1'b0, 8'h01, 3, 2, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
